// File: rtl/bot_seq_pkg.sv
// Shared types and field layout for the Rojobot motion-command sequencer.
package bot_seq_pkg;

    localparam int unsigned MOTCTL_W   = 8;
    localparam int unsigned DUR_W      = 8;
    localparam int unsigned CMD_W      = MOTCTL_W + DUR_W;
    localparam int unsigned MOTCTL_LSB = 0;
    localparam int unsigned DUR_LSB    = MOTCTL_W;
    localparam int unsigned STEP_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    // A zero duration still holds the entry for one update event.
    function automatic logic [DUR_W-1:0] load_duration(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? DUR_W'(1) : dur;
    endfunction

endpackage

// File: rtl/bot_cmd_fifo.sv
// Command FIFO with a registered head-of-queue output and synchronous flush.
module bot_cmd_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              wr_en, rd_en;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    always_comb begin
        rd_en     = pop & ~empty & ~flush;
        wr_en     = push & (~full | rd_en) & ~flush;
        rd_nxt    = rd_ptr + PTR_W'(rd_en);
        wr_nxt    = wr_ptr + PTR_W'(wr_en);
        count_nxt = count + CNT_W'(wr_en) - CNT_W'(rd_en);
        if (flush) begin
            rd_nxt    = '0;
            wr_nxt    = '0;
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // rdata always presents the entry that will be at the head after this edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            rdata  <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == CNT_W'(DEPTH));
            empty  <= (count_nxt == '0);
            rdata  <= (wr_en && (wr_ptr == rd_nxt)) ? wdata : mem[rd_nxt];
        end
    end

endmodule

// File: rtl/bot_cmd_sequencer.sv
// Drives Rojobot MotCtl from a queue of timed commands; raises done_irq when drained.
// Optional step counter output enabled by `define BOT_SEQ_STEP_COUNT_EN.
module bot_cmd_sequencer
    import bot_seq_pkg::*;
#(
    parameter int unsigned          DEPTH       = 8,
    parameter logic [MOTCTL_W-1:0]  IDLE_MOTCTL = 8'h00
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_wr,
    input  logic [CMD_W-1:0]        cmd_data,
    input  logic                    abort,
    input  logic                    irq_ack,
    input  logic                    upd_sysregs_100,
    output logic [MOTCTL_W-1:0]     mot_ctl,
    output logic                    busy,
    output logic                    cmd_full,
    output logic [$clog2(DEPTH):0]  cmd_count,
    output logic                    overflow,
    output logic                    done_irq
`ifdef BOT_SEQ_STEP_COUNT_EN
   ,output logic [STEP_W-1:0]       steps_done
`endif
);

    seq_state_t        state;
    logic [DUR_W-1:0]  remain;
    logic              upd_prev;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              fifo_empty;
    logic              upd_ev, fifo_pop, push_ok, terminal;

    always_comb begin
        upd_ev   = upd_sysregs_100 & ~upd_prev;
        fifo_pop = (state == LOAD) & ~abort;
        push_ok  = cmd_wr & ~abort & (~cmd_full | fifo_pop);
        terminal = (state == RUN) & upd_ev & (remain == DUR_W'(1)) & ~abort;
    end

    bot_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CMD_W)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push   (push_ok),
        .wdata  (cmd_data),
        .pop    (fifo_pop),
        .flush  (abort),
        .rdata  (fifo_rdata),
        .full   (cmd_full),
        .empty  (fifo_empty),
        .count  (cmd_count)
    );

    // Sequencer FSM; abort overrides everything except edge tracking and done_irq.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            remain   <= '0;
            upd_prev <= 1'b0;
            mot_ctl  <= IDLE_MOTCTL;
            busy     <= 1'b0;
            overflow <= 1'b0;
            done_irq <= 1'b0;
        end else begin
            upd_prev <= upd_sysregs_100;
            if (terminal && fifo_empty) begin
                done_irq <= 1'b1;
            end else if (irq_ack) begin
                done_irq <= 1'b0;
            end
            if (abort) begin
                state    <= IDLE;
                mot_ctl  <= IDLE_MOTCTL;
                busy     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (cmd_wr && !push_ok) begin
                    overflow <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (!fifo_empty || push_ok) begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        mot_ctl <= fifo_rdata[MOTCTL_LSB +: MOTCTL_W];
                        remain  <= load_duration(fifo_rdata[DUR_LSB +: DUR_W]);
                        state   <= RUN;
                    end
                    RUN: begin
                        if (upd_ev) begin
                            remain <= remain - DUR_W'(1);
                            if (terminal) begin
                                if (!fifo_empty) begin
                                    state <= LOAD;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BOT_SEQ_STEP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            steps_done <= '0;
        end else if (terminal && (steps_done != {STEP_W{1'b1}})) begin
            steps_done <= steps_done + STEP_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bot_cmd_sequencer.sv
// Directed bench for bot_cmd_sequencer: cycle table plus hand-written corner sequences.
module tb_bot_cmd_sequencer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_wr;
    logic [15:0] cmd_data;
    logic        abort;
    logic        irq_ack;
    logic        upd;
    logic [7:0]  mot_ctl;
    logic        busy;
    logic        cmd_full;
    logic [3:0]  cmd_count;
    logic        overflow;
    logic        done_irq;
`ifdef BOT_SEQ_STEP_COUNT_EN
    logic [15:0] steps_done;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bot_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .IDLE_MOTCTL (8'h00)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .cmd_wr          (cmd_wr),
        .cmd_data        (cmd_data),
        .abort           (abort),
        .irq_ack         (irq_ack),
        .upd_sysregs_100 (upd),
        .mot_ctl         (mot_ctl),
        .busy            (busy),
        .cmd_full        (cmd_full),
        .cmd_count       (cmd_count),
        .overflow        (overflow),
        .done_irq        (done_irq)
`ifdef BOT_SEQ_STEP_COUNT_EN
       ,.steps_done      (steps_done)
`endif
    );

    typedef struct {
        logic        wr;
        logic [15:0] data;
        logic        ab;
        logic        ack;
        logic        up;
        logic [7:0]  mot;
        logic        bsy;
        logic        full;
        logic [3:0]  cnt;
        logic        ovf;
        logic        irq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [15:0] data, input logic ab,
                         input logic ack, input logic up);
        cmd_wr   = wr;
        cmd_data = data;
        abort    = ab;
        irq_ack  = ack;
        upd      = up;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[22];
        // Row inputs are sampled at one edge; expectations are the outputs after it.
        vecs[0]  = '{1'b1, 16'h0311, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 16'h0233, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

        rstn = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("reset mot_ctl",   32'(mot_ctl),   32'h00);
        check("reset busy",      32'(busy),      32'h0);
        check("reset cmd_full",  32'(cmd_full),  32'h0);
        check("reset cmd_count", 32'(cmd_count), 32'h0);
        check("reset overflow",  32'(overflow),  32'h0);
        check("reset done_irq",  32'(done_irq),  32'h0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].wr, vecs[i].data, vecs[i].ab, vecs[i].ack, vecs[i].up);
            step();
            check($sformatf("vec%0d mot_ctl", i),   32'(mot_ctl),   32'(vecs[i].mot));
            check($sformatf("vec%0d busy", i),      32'(busy),      32'(vecs[i].bsy));
            check($sformatf("vec%0d cmd_full", i),  32'(cmd_full),  32'(vecs[i].full));
            check($sformatf("vec%0d cmd_count", i), 32'(cmd_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d overflow", i),  32'(overflow),  32'(vecs[i].ovf));
            check($sformatf("vec%0d done_irq", i),  32'(done_irq),  32'(vecs[i].irq));
        end
`ifdef BOT_SEQ_STEP_COUNT_EN
        check("steps after table", 32'(steps_done), 32'd3);
`endif

        // Hold one entry in RUN, then fill the queue past capacity.
        drive(1'b1, 16'h0144, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("holder mot_ctl", 32'(mot_ctl), 32'h44);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] m;
            m = 8'h50 + 8'(i);
            drive(1'b1, {8'd2, m}, 1'b0, 1'b0, 1'b0);
            step();
            if (i == 7) begin
                check("fill count 8",    32'(cmd_count), 32'd8);
                check("fill full",       32'(cmd_full),  32'h1);
                check("fill no overflow", 32'(overflow), 32'h0);
            end
        end
        check("9th push count", 32'(cmd_count), 32'd8);
        check("9th push overflow", 32'(overflow), 32'h1);

        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        check("terminal busy",  32'(busy),      32'h1);
        check("terminal count", 32'(cmd_count), 32'd8);
        check("terminal mot",   32'(mot_ctl),   32'h44);
        drive(1'b1, 16'h0260, 1'b0, 1'b0, 1'b0);
        step();
        check("push+pop count", 32'(cmd_count), 32'd8);
        check("push+pop full",  32'(cmd_full),  32'h1);
        check("push+pop mot",   32'(mot_ctl),   32'h50);
        check("push+pop ovf",   32'(overflow),  32'h1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();

        // Abort mid-RUN together with a push.
        drive(1'b1, 16'h0170, 1'b1, 1'b0, 1'b0);
        step();
        check("abort mot_ctl",  32'(mot_ctl),   32'h00);
        check("abort count",    32'(cmd_count), 32'd0);
        check("abort busy",     32'(busy),      32'h0);
        check("abort overflow", 32'(overflow),  32'h0);
        check("abort done_irq", 32'(done_irq),  32'h0);
        check("abort full",     32'(cmd_full),  32'h0);
`ifdef BOT_SEQ_STEP_COUNT_EN
        check("abort steps", 32'(steps_done), 32'd0);
`endif
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("post-abort busy",  32'(busy),      32'h0);
        check("post-abort count", 32'(cmd_count), 32'd0);

        // irq_ack coinciding with a drain event.
        drive(1'b1, 16'h0177, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("drain mot", 32'(mot_ctl), 32'h77);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        check("ack+drain irq",  32'(done_irq), 32'h1);
        check("ack+drain busy", 32'(busy),     32'h0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("irq held", 32'(done_irq), 32'h1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        step();
        check("irq acked", 32'(done_irq), 32'h0);
`ifdef BOT_SEQ_STEP_COUNT_EN
        check("final steps", 32'(steps_done), 32'd1);
`endif

        // Reset while running with a queued entry.
        drive(1'b1, 16'h0599, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h03AA, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        check("pre-reset mot", 32'(mot_ctl), 32'h99);
        rstn = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("midrun reset mot",   32'(mot_ctl),   32'h00);
        check("midrun reset busy",  32'(busy),      32'h0);
        check("midrun reset count", 32'(cmd_count), 32'd0);
        rstn = 1'b1;
        step();
        step();
        check("after reset busy", 32'(busy),    32'h0);
        check("after reset mot",  32'(mot_ctl), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
